norm_trunc_mult: RTL and testbench

Parametrised sequential normalise–multiply–denormalise unit: latches two unsigned operands, left-normalises each one bit per cycle while counting the shifts, multiplies the normalised operands, then right-shifts the product back by the total shift count. It carries its own datapath and FSM. It adds an exact/truncated mode select, zero-operand early exit and a start/busy/done handshake. It sits beside the existing shift-add arithmetic blocks as their configurable-width replacement.

---
 rtl/norm_trunc_mult.sv | 114 +++++++++++
 tb/tb_norm_trunc_mult.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/norm_trunc_mult.sv
// rtl/norm_trunc_mult.sv - sequential normalise/multiply/denormalise unit
// Operands are left-normalised one bit per cycle, multiplied (exact or truncated), then shifted back.
module norm_trunc_mult #(
  parameter int WIDTH = 16,
  parameter int KEEP  = 8,
  localparam int CW   = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               exact,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [CW-1:0]      shift_total
);

  typedef enum logic [2:0] {IDLE, NORM_A, NORM_B, MULT, SHR, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   ra, rb;
  logic               ex;
  logic [CW-1:0]      cnt, tot;
  logic [2*WIDTH-1:0] p;
  logic               zero_op;
  logic [2*WIDTH-1:0] full_prod;
  logic [2*KEEP-1:0]  trunc_core;
  logic [2*WIDTH-1:0] trunc_prod;

  assign zero_op    = (a == '0) || (b == '0);
  assign full_prod  = (2*WIDTH)'(ra) * (2*WIDTH)'(rb);
  assign trunc_core = (2*KEEP)'(ra[WIDTH-1 -: KEEP]) * (2*KEEP)'(rb[WIDTH-1 -: KEEP]);
  // Truncated product is realigned so its weight matches the full normalised product.
  assign trunc_prod = (2*WIDTH)'(trunc_core) << (2*WIDTH - 2*KEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_op ? DONE : NORM_A;
      NORM_A:  if (ra[WIDTH-1]) state_nxt = NORM_B;
      NORM_B:  if (rb[WIDTH-1]) state_nxt = MULT;
      MULT:    state_nxt = SHR;
      SHR:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra          <= '0;
      rb          <= '0;
      ex          <= 1'b0;
      cnt         <= '0;
      tot         <= '0;
      p           <= '0;
      result      <= '0;
      shift_total <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            ex  <= exact;
            cnt <= '0;
            if (zero_op) begin
              result      <= '0;
              shift_total <= '0;
            end
          end
        end
        NORM_A: begin
          if (!ra[WIDTH-1]) begin
            ra  <= ra << 1;
            cnt <= cnt + CW'(1);
          end
        end
        NORM_B: begin
          if (!rb[WIDTH-1]) begin
            rb  <= rb << 1;
            cnt <= cnt + CW'(1);
          end
        end
        MULT: begin
          p   <= ex ? full_prod : trunc_prod;
          tot <= cnt;
        end
        SHR: begin
          if (cnt != '0) begin
            p   <= p >> 1;
            cnt <= cnt - CW'(1);
          end else begin
            result      <= p;
            shift_total <= tot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_trunc_mult.sv
// tb/tb_norm_trunc_mult.sv - self-checking bench for norm_trunc_mult
// Cycle model tracks busy/done/result per operation; compared on every falling edge.
module tb_norm_trunc_mult;
  localparam int W  = 16;
  localparam int K  = 8;
  localparam int CW = $clog2(2*W);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           exact = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done;
  logic [2*W-1:0] result;
  logic [CW-1:0]  shift_total;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  norm_trunc_mult #(.WIDTH(W), .KEEP(K)) dut (
    .clk(clk), .rst(rst), .start(start), .exact(exact), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .shift_total(shift_total)
  );

  function automatic int lz(input logic [W-1:0] v);
    for (int i = W-1; i >= 0; i--) if (v[i]) return W-1-i;
    return W;
  endfunction

  function automatic int lat_of(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == 0 || y == 0) return 1;
    return 2*(lz(x) + lz(y)) + 5;
  endfunction

  function automatic logic [CW-1:0] sh_of(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == 0 || y == 0) return '0;
    return CW'(lz(x) + lz(y));
  endfunction

  function automatic logic [2*W-1:0] prod_of(input logic [W-1:0] x, input logic [W-1:0] y, input logic e);
    logic [63:0] nx, ny, pr;
    if (x == 0 || y == 0) return '0;
    nx = 64'(x) << lz(x);
    ny = 64'(y) << lz(y);
    if (e) pr = 64'(x) * 64'(y);
    else   pr = (((nx >> (W-K)) * (ny >> (W-K))) << (2*W-2*K)) >> (lz(x) + lz(y));
    return pr[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: cycles remaining until the end of the DONE cycle.
  int             m_left = 0;
  logic [2*W-1:0] m_res = '0, m_pres = '0;
  logic [CW-1:0]  m_sh = '0, m_psh = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_res  <= '0;
      m_sh   <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left <= lat_of(a, b);
        m_pres <= prod_of(a, b, exact);
        m_psh  <= sh_of(a, b);
        if (lat_of(a, b) == 1) begin
          m_res <= '0;
          m_sh  <= '0;
        end
      end
    end else begin
      if (m_left == 2) begin
        m_res <= m_pres;
        m_sh  <= m_psh;
      end
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_left != 0));
    chk("done", 64'(done), 64'(m_left == 1));
    chk("result", 64'(result), 64'(m_res));
    chk("shift_total", 64'(shift_total), 64'(m_sh));
  end

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic e,
                     input bit lit, input int exp_lat, input logic [63:0] exp_res, input int exp_sh);
    int k;
    @(negedge clk);
    a = x; b = y; exact = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'(lat_of(x, y)));
    if (e) chk("exact_prod", 64'(result), 64'(x) * 64'(y));
    if (lit) begin
      chk("lit_latency", 64'(k), 64'(exp_lat));
      chk("lit_result", 64'(result), exp_res);
      chk("lit_shift", 64'(shift_total), 64'(exp_sh));
    end
  endtask

  initial begin
    int k;
    bit saw_done;
    logic [W-1:0] x, y;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    rst = 1'b0;

    chk("pin_lat_3_5", 64'(lat_of(16'd3, 16'd5)), 64'(59));
    chk("pin_trunc_ff", 64'(prod_of(16'h00FF, 16'h0101, 1'b0)), 64'h0000FF00);
    chk("pin_trunc_8000", 64'(prod_of(16'h8000, 16'h8000, 1'b0)), 64'h40000000);

    run(16'd3, 16'd5, 1'b1, 1'b1, 59, 64'd15, 27);
    run(16'h00FF, 16'h0101, 1'b0, 1'b1, 35, 64'hFF00, 15);
    run(16'h8000, 16'h8000, 1'b0, 1'b1, 5, 64'h40000000, 0);
    run(16'h0000, 16'h1234, 1'b1, 1'b1, 1, 64'd0, 0);
    run(16'h1234, 16'h0000, 1'b0, 1'b1, 1, 64'd0, 0);
    run(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 5, 64'hFE010000, 0);
    run(16'd1, 16'd1, 1'b1, 1'b1, 65, 64'd1, 30);

    // Re-pulse start during NORM_B (cycle 20) and SHR (cycle 40); both must be ignored.
    @(negedge clk);
    a = 16'd3; b = 16'd5; exact = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 20 || k == 40) begin
        start = 1'b1; a = 16'h8000; b = 16'h8000; exact = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    chk("repulse_latency", 64'(k), 64'(59));
    chk("repulse_result", 64'(result), 64'd15);
    chk("repulse_shift", 64'(shift_total), 64'd27);

    // Reset mid-SHR aborts the operation without a done pulse.
    @(negedge clk);
    a = 16'd3; b = 16'd5; exact = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (44) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_shift", 64'(shift_total), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'(0));
    run(16'h00FF, 16'h0101, 1'b0, 1'b1, 35, 64'hFF00, 15);

    for (int n = 0; n < 1000; n++) begin
      x = W'($urandom) >> $urandom_range(0, W);
      y = W'($urandom) >> $urandom_range(0, W);
      run(x, y, 1'b1, 1'b0, 0, 64'd0, 0);
    end
    for (int n = 0; n < 150; n++) begin
      x = W'($urandom) >> $urandom_range(0, W);
      y = W'($urandom) >> $urandom_range(0, W);
      run(x, y, 1'(($urandom)), 1'b0, 0, 64'd0, 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
